ocp_cpl_tlp_gen: RTL
====================

// Module: ocp_cpl_tlp_gen
// PURPOSE
//  Return path that pairs with the AXI->OCP request translator. Takes a read-request context
//  (requester ID, tag, lower address, length) and the OCP byte-wide read response stream.
//  Builds one PCIe completion TLP (CplD, or Cpl on error) with a 3DW header.
//  Emits the TLP as a 64-bit AXI4-Stream toward the TX FIFO.
//  Store-and-forward: the whole payload is buffered before the header goes out, so the status is known.
// PARAMETERS
//  COMPLETER_ID    16'h0100  completer ID placed in DW1[31:16]
//  MAX_PAYLOAD_DW  32        payload buffer depth in DW; legal ctx_length is 1..MAX_PAYLOAD_DW
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high
//  ctx_valid       in   1   request context valid
//  ctx_ready       out  1   context accepted when ctx_valid & ctx_ready
//  ctx_req_id      in   16  requester ID
//  ctx_tag         in   8   request tag
//  ctx_lower_addr  in   7   lower address of the first byte
//  ctx_length      in   10  requested length in DW
//  ctx_tc          in   3   traffic class
//  ctx_attr        in   2   attributes
//  s_resp          in   2   OCP SResp: 00 NULL, 01 DVA, 10 FAIL, 11 ERR
//  s_data          in   8   OCP SData byte
//  s_resp_last     in   1   OCP SRespLast
//  m_resp_accept   out  1   OCP MRespAccept
//  m_axis_tvalid   out  1   TLP beat valid
//  m_axis_tready   in   1   downstream ready
//  m_axis_tdata    out  64  beat data; lower DW in [31:0]
//  m_axis_tkeep    out  8   byte enables
//  m_axis_tlast    out  1   last beat of the TLP
// BEHAVIOUR
//  Reset: state=IDLE; byte_cnt, status and flags cleared.
//   Every output is 0 while reset is high.
//   Reset mid-TLP drops the context and partial buffer; m_axis_tvalid is 0 on the next cycle.
//  States (one-hot):
//   IDLE    ctx_ready=1; on ctx handshake, capture all ctx_* fields and set status=SC (000).
//           If ctx_length==0 or ctx_length>MAX_PAYLOAD_DW: status=CA (100), nodata=1, go to HDR0.
//           Otherwise go to COLLECT.
//   COLLECT m_resp_accept=1. Each cycle with s_resp!=NULL consumes one byte.
//           The byte is written to buf[byte_cnt] (byte 0 goes to DW lane [7:0]) and byte_cnt increments.
//           FAIL sets status=CA; ERR sets status=UR (001). The first error wins; error beats still count.
//           s_resp_last before byte_cnt==4*len-1 sets status=CA and goes to HDR0.
//           Accepting byte 4*len-1 goes to HDR0.
//           If status!=SC at exit, nodata=1.
//   HDR0    beat {DW1,DW0}, tkeep=FF. On tready go to HDR1.
//   HDR1    beat {buf DW0 or 0, DW2}.
//           tkeep=0F if nodata, otherwise FF.
//           tlast=1 if nodata or len==1.
//           On tready: go to IDLE if tlast, otherwise go to PAYLOAD with rd_dw=1.
//   PAYLOAD beat {buf[rd_dw+1], buf[rd_dw]}.
//           If only one DW remains: tkeep=0F, upper DW=0.
//           tlast when remaining DW<=2.
//           On tready: rd_dw+=2. On tlast, go to IDLE.
//  Header fields:
//   DW0: Fmt[30:29]=10 for CplD, 00 for Cpl; Type[28:24]=01010; TC[22:20]; Attr[13:12];
//        Length[9:0]=len for CplD, 0 for Cpl.
//   DW1: COMPLETER_ID[31:16]; Status[15:13]; BCM[12]=0; ByteCount[11:0]=4*len (12-bit truncation).
//   DW2: ReqID[31:16]; Tag[15:8]; [7]=0; LowerAddr[6:0].
//  AXI rule: tdata, tkeep and tlast are held stable while tvalid & !tready.
//   tvalid never drops before its handshake.
//  Latency: tvalid (HDR0) rises 1 cycle after the final byte is accepted.
//   COLLECT throughput is 1 byte per cycle.
//  A new context is not accepted until the tlast handshake completes.
//   Back-to-back TLPs are separated by one IDLE cycle.
// STRUCTURE
//  Shared package (ocp_pcie_pkg): SResp codes, completion status codes (SC/UR/CA),
//   Fmt/Type constants, state encodings.
//  Sub-module cpl_payload_buf: MAX_PAYLOAD_DW x 32 flop array.
//   One byte-write port (byte index, data, we); two combinational DW read ports (rd_dw, rd_dw+1).
//  Top level: FSM, context registers, counters and beat mux.
// TESTING
//  T1: len=1, bytes 11,22,33,44 DVA, tready=1.
//      -> beat0 DW0=0x4A000001, DW1={COMPLETER_ID,16'h0004}.
//      -> beat1 {0x44332211,DW2}, tkeep=FF, tlast=1.
//  T2: len=2, bytes 01..08.
//      -> 3 beats; beat1 upper=0x04030201; beat2={32'h0,0x08070605}, tkeep=0F, tlast=1.
//  T3: len=2, ERR on byte 2, all 8 bytes consumed.
//      -> DW0=0x0A000000, DW1 status=001, byte count=8; 2 beats, beat1 tkeep=0F, tlast=1.
//  T4: ctx_length=0, then ctx_length=33.
//      -> each gives an immediate Cpl with status=100 (CA); m_resp_accept stays 0.
//  T5: len=4 with random tready stalls (50%).
//      -> beats are bit-identical to the no-stall run; tvalid never drops mid-TLP.
//  T6: reset pulsed during PAYLOAD of a len=4 TLP, then a len=1 request.
//      -> tvalid=0 the cycle after reset; the second TLP matches T1.

Source files
------------

// File: rtl/ocp_pcie_pkg.sv
// Shared constants for the OCP <-> PCIe bridge: OCP response codes, completion
// status codes, TLP format/type fields and the completion generator state encodings.
package ocp_pcie_pkg;

    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_FAIL = 2'b10;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    localparam logic [2:0] CPL_SC = 3'b000;
    localparam logic [2:0] CPL_UR = 3'b001;
    localparam logic [2:0] CPL_CA = 3'b100;

    localparam logic [1:0] FMT_3DW_NODATA = 2'b00;
    localparam logic [1:0] FMT_3DW_DATA   = 2'b10;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    // One-hot completion generator states
    localparam logic [4:0] ST_IDLE    = 5'b00001;
    localparam logic [4:0] ST_COLLECT = 5'b00010;
    localparam logic [4:0] ST_HDR0    = 5'b00100;
    localparam logic [4:0] ST_HDR1    = 5'b01000;
    localparam logic [4:0] ST_PAYLOAD = 5'b10000;

    function automatic logic [2:0] resp_status(input logic [1:0] resp);
        case (resp)
            SRESP_FAIL: return CPL_CA;
            SRESP_ERR:  return CPL_UR;
            SRESP_DVA:  return CPL_SC;
            default:    return CPL_SC;
        endcase
    endfunction

endpackage

// File: rtl/cpl_payload_buf.sv
// Completion payload store: byte-granular write port, two combinational DW read
// ports. Reads past the last DW return zero so the caller can index rd_dw+1 freely.
module cpl_payload_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW+1:0] wr_byte,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   rd_idx0,
    input  logic [AW:0]   rd_idx1,
    output logic [31:0]   rd_data0,
    output logic [31:0]   rd_data1
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_byte[AW+1:2]][8*wr_byte[1:0] +: 8] <= wr_data;
        end
    end

    assign rd_data0 = (rd_idx0 < (AW+1)'(DEPTH)) ? mem[rd_idx0[AW-1:0]] : 32'h0;
    assign rd_data1 = (rd_idx1 < (AW+1)'(DEPTH)) ? mem[rd_idx1[AW-1:0]] : 32'h0;

endmodule

// File: rtl/ocp_cpl_tlp_gen.sv
// Builds one PCIe completion (CplD, or Cpl on error) per read context from the OCP
// byte response stream; payload is fully buffered so the header carries final status.
module ocp_cpl_tlp_gen
    import ocp_pcie_pkg::*;
#(
    parameter logic [15:0] COMPLETER_ID   = 16'h0100,
    parameter int          MAX_PAYLOAD_DW = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctx_valid,
    output logic        ctx_ready,
    input  logic [15:0] ctx_req_id,
    input  logic [7:0]  ctx_tag,
    input  logic [6:0]  ctx_lower_addr,
    input  logic [9:0]  ctx_length,
    input  logic [2:0]  ctx_tc,
    input  logic [1:0]  ctx_attr,
    input  logic [1:0]  s_resp,
    input  logic [7:0]  s_data,
    input  logic        s_resp_last,
    output logic        m_resp_accept,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast
);

    localparam int AW = $clog2(MAX_PAYLOAD_DW);

    logic [4:0]  state;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [6:0]  lower_addr;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [2:0]  status;
    logic        nodata;
    logic [11:0] byte_cnt;
    logic [AW:0] rd_dw;

    logic        ctx_fire, ctx_bad, byte_take, last_byte;
    logic [2:0]  status_nxt;
    logic [9:0]  remaining;
    logic [AW:0] rd_base;
    logic [31:0] rd_data0, rd_data1, dw0, dw1, dw2;
    logic        beat_valid, beat_last;
    logic [63:0] beat_data;
    logic [7:0]  beat_keep;

    assign ctx_fire  = (state == ST_IDLE) && ctx_valid;
    assign ctx_bad   = (ctx_length == 10'd0) || (ctx_length > 10'(MAX_PAYLOAD_DW));
    assign byte_take = (state == ST_COLLECT) && (s_resp != SRESP_NULL);
    assign last_byte = byte_cnt == ({len, 2'b00} - 12'd1);
    assign remaining = len - 10'(rd_dw);

    // First error wins; a premature SRespLast is a completer abort.
    always_comb begin
        status_nxt = status;
        if (status == CPL_SC) begin
            status_nxt = resp_status(s_resp);
            if (status_nxt == CPL_SC && s_resp_last && !last_byte) begin
                status_nxt = CPL_CA;
            end
        end
    end

    assign rd_base = (state == ST_HDR1) ? '0 : rd_dw;

    cpl_payload_buf #(.DEPTH(MAX_PAYLOAD_DW), .AW(AW)) u_buf (
        .clk      (clk),
        .we       (byte_take),
        .wr_byte  (byte_cnt[AW+1:0]),
        .wr_data  (s_data),
        .rd_idx0  (rd_base),
        .rd_idx1  (rd_base + (AW+1)'(1)),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    assign dw0 = {1'b0, nodata ? FMT_3DW_NODATA : FMT_3DW_DATA, TYPE_CPL, 1'b0, tc,
                  6'b0, attr, 2'b0, nodata ? 10'd0 : len};
    assign dw1 = {COMPLETER_ID, status, 1'b0, {len, 2'b00}};
    assign dw2 = {req_id, tag, 1'b0, lower_addr};

    // Beat outputs depend only on registered state, so they stay stable while
    // tvalid is high and tready is low; a beat transfers on tvalid & tready.
    always_comb begin
        beat_valid = 1'b0;
        beat_data  = 64'h0;
        beat_keep  = 8'h00;
        beat_last  = 1'b0;
        case (state)
            ST_HDR0: begin
                beat_valid = 1'b1;
                beat_data  = {dw1, dw0};
                beat_keep  = 8'hFF;
            end
            ST_HDR1: begin
                beat_valid = 1'b1;
                beat_data  = {nodata ? 32'h0 : rd_data0, dw2};
                beat_keep  = nodata ? 8'h0F : 8'hFF;
                beat_last  = nodata || (len == 10'd1);
            end
            ST_PAYLOAD: begin
                beat_valid = 1'b1;
                beat_data  = {(remaining == 10'd1) ? 32'h0 : rd_data1, rd_data0};
                beat_keep  = (remaining == 10'd1) ? 8'h0F : 8'hFF;
                beat_last  = remaining <= 10'd2;
            end
            default: ;
        endcase
    end

    assign ctx_ready     = !reset && (state == ST_IDLE);
    assign m_resp_accept = !reset && (state == ST_COLLECT);
    assign m_axis_tvalid = !reset && beat_valid;
    assign m_axis_tdata  = reset ? 64'h0 : beat_data;
    assign m_axis_tkeep  = reset ? 8'h00 : beat_keep;
    assign m_axis_tlast  = !reset && beat_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len        <= '0;
            req_id     <= '0;
            tag        <= '0;
            lower_addr <= '0;
            tc         <= '0;
            attr       <= '0;
            status     <= CPL_SC;
            nodata     <= 1'b0;
            byte_cnt   <= '0;
            rd_dw      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctx_fire) begin
                        len        <= ctx_length;
                        req_id     <= ctx_req_id;
                        tag        <= ctx_tag;
                        lower_addr <= ctx_lower_addr;
                        tc         <= ctx_tc;
                        attr       <= ctx_attr;
                        byte_cnt   <= '0;
                        rd_dw      <= '0;
                        status     <= ctx_bad ? CPL_CA : CPL_SC;
                        nodata     <= ctx_bad;
                        state      <= ctx_bad ? ST_HDR0 : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (byte_take) begin
                        byte_cnt <= byte_cnt + 12'd1;
                        status   <= status_nxt;
                        if (last_byte || s_resp_last) begin
                            nodata <= status_nxt != CPL_SC;
                            state  <= ST_HDR0;
                        end
                    end
                end
                ST_HDR0: begin
                    if (m_axis_tready) state <= ST_HDR1;
                end
                ST_HDR1: begin
                    if (m_axis_tready) begin
                        rd_dw <= (AW+1)'(1);
                        state <= beat_last ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (m_axis_tready) begin
                        rd_dw <= rd_dw + (AW+1)'(2);
                        if (beat_last) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
